// File: rtl/i2s_tx_pkg.sv
// Shared audio constants and small helpers for the I2S transmitter.
package i2s_tx_pkg;

  // Sample/slot geometry shared with the tone generators.
  localparam int AUDIO_SAMPLE_W = 24;
  localparam int I2S_SLOT_W     = 32;
  localparam int I2S_BCLK_DIV   = 8;

  // LRCK level names: low selects the left slot, high the right slot.
  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  // True when frame bit position n carries sample data (left or right),
  // false for the one-bit I2S delay slot and the zero padding.
  function automatic logic is_data_bit(input int n, input int sample_w, input int slot_w);
    return ((n >= 1) && (n <= sample_w)) ||
           ((n >= slot_w + 1) && (n <= slot_w + sample_w));
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Ready/valid sample stream from a stereo producer into the I2S transmitter.
interface i2s_tx_if
  import i2s_tx_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_W
);

  logic [SAMPLE_WIDTH-1:0] sample_l;
  logic [SAMPLE_WIDTH-1:0] sample_r;
  logic                    sample_valid;
  logic                    sample_ready;

  // Producer side (tone generator).
  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  // Consumer side (transmitter).
  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_tx_bclk_div.sv
// Bit-clock generator: divides sys_clk into a 50% duty BCLK and reports
// the sys_clk cycle on which BCLK is about to rise or fall.
module i2s_tx_bclk_div
  import i2s_tx_pkg::*;
#(
  parameter int BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic sys_clk,
  input  logic data_reset,
  output logic bclk_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  // Half-period counter; BCLK toggles each time the counter wraps.
  always_comb begin
    wrap      = (div_cnt_q == DW'(BCLK_DIV - 1));
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d    = wrap ? ~bclk_q : bclk_q;
  end

  // Divider state; reset leaves BCLK low at the start of a half-period.
  always_ff @(posedge sys_clk or posedge data_reset) begin
    if (data_reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o     = bclk_q;
  assign rise_stb_o = wrap && !bclk_q;
  assign fall_stb_o = wrap &&  bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S master transmitter: one-pair holding buffer with ready/valid
// intake, frame latch with underrun replay, and MSB-first serialisation
// of both channels one BCLK after each LRCK edge.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int BCLK_DIV     = I2S_BCLK_DIV,
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_W,
  parameter int SLOT_WIDTH   = I2S_SLOT_W
) (
  input  logic     sys_clk,
  input  logic     data_reset,
  i2s_tx_if.slave  snd,
  output logic     frame_tick,
  output logic     underrun,
  output logic     bclk,
  output logic     lrclk,
  output logic     sdata
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int BCW        = $clog2(FRAME_BITS);
  localparam int SHW        = 2 * SAMPLE_WIDTH;

  // Geometry sanity: data must leave room for the I2S delay bit, and the
  // divider needs at least two cycles per half-period.
  if (SAMPLE_WIDTH >= SLOT_WIDTH) begin : g_bad_width
    $error("i2s_tx: SAMPLE_WIDTH (%0d) must be smaller than SLOT_WIDTH (%0d)",
           SAMPLE_WIDTH, SLOT_WIDTH);
  end
  if (BCLK_DIV < 2) begin : g_bad_div
    $error("i2s_tx: BCLK_DIV (%0d) must be at least 2", BCLK_DIV);
  end

  logic bclk_rise, bclk_fall;

  i2s_tx_bclk_div #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_div (
    .sys_clk    (sys_clk),
    .data_reset (data_reset),
    .bclk_o     (bclk),
    .rise_stb_o (bclk_rise),
    .fall_stb_o (bclk_fall)
  );

  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d, bit_nxt;
  slot_e                   lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic                    frame_tick_q, frame_tick_d;
  logic                    underrun_q, underrun_d;
  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [SAMPLE_WIDTH-1:0] last_l_q, last_l_d;
  logic [SAMPLE_WIDTH-1:0] last_r_q, last_r_d;
  logic [SHW-1:0]          shifter_q, shifter_d;
  logic                    accept;

  // Bit sequencing, frame latch and holding-register handshake. The latch
  // looks at the holding state from before this cycle's write, so a pair
  // accepted on the latch cycle is kept for the following frame.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    lrclk_d      = lrclk_q;
    sdata_d      = sdata_q;
    frame_tick_d = 1'b0;
    underrun_d   = 1'b0;
    hold_full_d  = hold_full_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    last_l_d     = last_l_q;
    last_r_d     = last_r_q;
    shifter_d    = shifter_q;

    accept  = snd.sample_valid && !hold_full_q;
    bit_nxt = (bit_cnt_q == BCW'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + 1'b1;

    if (bclk_fall) begin
      bit_cnt_d = bit_nxt;
      lrclk_d   = (int'(bit_nxt) >= SLOT_WIDTH) ? SLOT_RIGHT : SLOT_LEFT;

      if (bit_nxt == '0) begin
        frame_tick_d = 1'b1;
        sdata_d      = 1'b0;
        if (hold_full_q) begin
          shifter_d   = {hold_l_q, hold_r_q};
          last_l_d    = hold_l_q;
          last_r_d    = hold_r_q;
          hold_full_d = 1'b0;
        end else begin
          shifter_d  = {last_l_q, last_r_q};
          underrun_d = 1'b1;
        end
      end else if (is_data_bit(int'(bit_nxt), SAMPLE_WIDTH, SLOT_WIDTH)) begin
        sdata_d   = shifter_q[SHW-1];
        shifter_d = {shifter_q[SHW-2:0], 1'b0};
      end else begin
        sdata_d = 1'b0;
      end
    end

    if (accept) begin
      hold_l_d    = snd.sample_l;
      hold_r_d    = snd.sample_r;
      hold_full_d = 1'b1;
    end
  end

  // State registers. data_reset arrives already release-synchronised from
  // the system reset controller; assertion aborts any frame in progress.
  always_ff @(posedge sys_clk or posedge data_reset) begin
    if (data_reset) begin
      bit_cnt_q    <= BCW'(FRAME_BITS - 1);
      lrclk_q      <= SLOT_LEFT;
      sdata_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      underrun_q   <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      last_l_q     <= '0;
      last_r_q     <= '0;
      shifter_q    <= '0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      frame_tick_q <= frame_tick_d;
      underrun_q   <= underrun_d;
      hold_full_q  <= hold_full_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      last_l_q     <= last_l_d;
      last_r_q     <= last_r_d;
      shifter_q    <= shifter_d;
    end
  end

  assign snd.sample_ready = !hold_full_q;
  assign frame_tick       = frame_tick_q;
  assign underrun         = underrun_q;
  assign lrclk            = lrclk_q;
  assign sdata            = sdata_q;

  // BCLK edges alternate, so a rise and a fall can never share a cycle.
  a_strobe_exclusive : assert property (
    @(posedge sys_clk) disable iff (data_reset) !(bclk_rise && bclk_fall)
  );

endmodule

// File: tb/tb_i2s_tx.sv
// Testbench for i2s_tx: scenario tasks plus a frame-level reference model
// that predicts BCLK/LRCK/SDATA, ready and underrun every cycle.
module tb_i2s_tx;

  localparam int SW        = 24;
  localparam int SLOT      = 32;
  localparam int HALF      = 8;
  localparam int BIT_CYC   = 2 * HALF;
  localparam int FRAME_CYC = BIT_CYC * 2 * SLOT;

  logic sys_clk = 1'b0;
  logic data_reset;
  logic frame_tick, underrun, bclk, lrclk, sdata;

  int n_cmp = 0;
  int n_bad = 0;

  i2s_tx_if #(.SAMPLE_WIDTH(SW)) snd ();

  i2s_tx #(
    .BCLK_DIV     (HALF),
    .SAMPLE_WIDTH (SW),
    .SLOT_WIDTH   (SLOT)
  ) dut (
    .sys_clk    (sys_clk),
    .data_reset (data_reset),
    .snd        (snd),
    .frame_tick (frame_tick),
    .underrun   (underrun),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- reference model (sampled on falling sys_clk) ----------
  logic [SW-1:0] q_l[$];
  logic [SW-1:0] q_r[$];
  logic [SW-1:0] cur_l = '0, cur_r = '0, last_l = '0, last_r = '0;
  logic [SW-1:0] pend_l = '0, pend_r = '0;
  bit            pend_v = 1'b0;
  bit            in_frame = 1'b0;
  bit            exp_ur;
  int            t = 0;

  always @(negedge sys_clk) begin
    if (data_reset !== 1'b0) begin
      q_l.delete(); q_r.delete();
      cur_l = '0; cur_r = '0; last_l = '0; last_r = '0;
      pend_v = 1'b0; in_frame = 1'b0; t = 0;
    end else begin
      if (frame_tick === 1'b1) begin
        if (q_l.size() > 0) begin
          cur_l = q_l.pop_front(); cur_r = q_r.pop_front();
          last_l = cur_l; last_r = cur_r; exp_ur = 1'b0;
        end else begin
          cur_l = last_l; cur_r = last_r; exp_ur = 1'b1;
        end
        n_cmp++;
        if (underrun !== exp_ur) begin
          n_bad++; $display("FAIL mon_underrun got %b want %b", underrun, exp_ur);
        end
        if (in_frame) begin
          n_cmp++;
          if (t + 1 != FRAME_CYC) begin
            n_bad++; $display("FAIL mon_frame_period got %0d want %0d", t + 1, FRAME_CYC);
          end
        end
        t = 0; in_frame = 1'b1;
      end else begin
        n_cmp++;
        if (underrun !== 1'b0) begin
          n_bad++; $display("FAIL mon_stray_underrun got %b want 0", underrun);
        end
        if (in_frame) t++;
      end
      if (pend_v) begin q_l.push_back(pend_l); q_r.push_back(pend_r); end
      pend_v = (snd.sample_valid === 1'b1) && (snd.sample_ready === 1'b1);
      pend_l = snd.sample_l; pend_r = snd.sample_r;
      n_cmp++;
      if (snd.sample_ready !== (q_l.size() == 0)) begin
        n_bad++; $display("FAIL mon_ready got %b want %b", snd.sample_ready, q_l.size() == 0);
      end
      if (in_frame) begin
        int   n;
        logic eb, el, ed;
        n  = t / BIT_CYC;
        eb = ((t % BIT_CYC) >= HALF);
        el = (n >= SLOT);
        if (n >= 1 && n <= SW)                    ed = cur_l[SW - n];
        else if (n >= SLOT + 1 && n <= SLOT + SW) ed = cur_r[SW - (n - SLOT)];
        else                                      ed = 1'b0;
        n_cmp++;
        if ({bclk, lrclk, sdata} !== {eb, el, ed}) begin
          n_bad++;
          $display("FAIL mon_serial t=%0d got bclk/lrclk/sdata %b%b%b want %b%b%b",
                   t, bclk, lrclk, sdata, eb, el, ed);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_tick(input int bound, output bit found, output int cycles);
    found = 1'b0; cycles = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge sys_clk); #1;
      cycles++;
      if (frame_tick === 1'b1) begin found = 1'b1; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit found; int cyc;
    data_reset = 1'b1;
    snd.sample_valid = 1'b0; snd.sample_l = '0; snd.sample_r = '0;
    #1;
    n_cmp++;
    if ({bclk, lrclk, sdata, frame_tick, underrun, snd.sample_ready} !== 6'b000001) begin
      n_bad++;
      $display("FAIL reset_outputs got %b want 000001",
               {bclk, lrclk, sdata, frame_tick, underrun, snd.sample_ready});
    end
    repeat (3) @(posedge sys_clk);
    #1 data_reset = 1'b0;
    wait_tick(40, found, cyc);
    n_cmp++;
    if (!found || cyc != 2 * HALF) begin
      n_bad++; $display("FAIL reset_first_tick got %0d cycles (found=%0d) want %0d", cyc, found, 2 * HALF);
    end
    n_cmp++;
    if (underrun !== 1'b1) begin
      n_bad++; $display("FAIL reset_first_underrun got %b want 1", underrun);
    end
    for (int f = 0; f < 3; f++) begin
      wait_tick(FRAME_CYC + 50, found, cyc);
      n_cmp++;
      if (!found || cyc != FRAME_CYC || underrun !== 1'b1) begin
        n_bad++;
        $display("FAIL idle_frame%0d got cycles=%0d underrun=%b want %0d/1", f, cyc, underrun, FRAME_CYC);
      end
    end
  endtask

  task automatic test_single_pair();
    bit found; int cyc;
    logic [SW-1:0]     l, r;
    logic [2*SLOT-1:0] got, exp_frame;
    l = 24'hA5A5A5; r = 24'h123456;
    snd.sample_l = l; snd.sample_r = r; snd.sample_valid = 1'b1;
    n_cmp++;
    if (snd.sample_ready !== 1'b1) begin
      n_bad++; $display("FAIL single_ready_before got %b want 1", snd.sample_ready);
    end
    @(posedge sys_clk); #1;
    snd.sample_valid = 1'b0;
    n_cmp++;
    if (snd.sample_ready !== 1'b0) begin
      n_bad++; $display("FAIL single_ready_after_accept got %b want 0", snd.sample_ready);
    end
    wait_tick(FRAME_CYC + 50, found, cyc);
    n_cmp++;
    if (!found || underrun !== 1'b0 || snd.sample_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_latch got found=%0d underrun=%b ready=%b want 1/0/1", found, underrun, snd.sample_ready);
    end
    exp_frame = {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    got = '0;
    repeat (HALF) @(posedge sys_clk);
    for (int n = 0; n < 2 * SLOT; n++) begin
      #1 got[2 * SLOT - 1 - n] = sdata;
      if (n < 2 * SLOT - 1) repeat (BIT_CYC) @(posedge sys_clk);
    end
    n_cmp++;
    if (got !== exp_frame) begin
      n_bad++; $display("FAIL single_frame_bits got %h want %h", got, exp_frame);
    end
  endtask

  task automatic test_back_to_back();
    bit found; int cyc;
    int ticks = 0, urs = 0, sent = 0;
    bit acc;
    wait_tick(FRAME_CYC + 50, found, cyc);
    snd.sample_l = 24'($urandom); snd.sample_r = 24'($urandom); snd.sample_valid = 1'b1;
    for (int c = 0; c < 7 * FRAME_CYC && ticks < 6; c++) begin
      acc = (snd.sample_ready === 1'b1);
      @(posedge sys_clk); #1;
      if (frame_tick === 1'b1) begin
        ticks++;
        if (underrun === 1'b1) urs++;
      end
      if (acc) begin
        sent++;
        snd.sample_l = 24'($urandom); snd.sample_r = 24'($urandom);
      end
    end
    snd.sample_valid = 1'b0;
    n_cmp++;
    if (ticks != 6 || urs != 0) begin
      n_bad++; $display("FAIL stream_underruns got ticks=%0d underruns=%0d want 6/0", ticks, urs);
    end
    n_cmp++;
    if (sent != 6) begin
      n_bad++; $display("FAIL stream_accepts got %0d want 6", sent);
    end
  endtask

  task automatic test_replay();
    bit found; int cyc;
    logic [3:0] seq = '0;
    snd.sample_l = 24'h800000; snd.sample_r = 24'h7FFFFF; snd.sample_valid = 1'b1;
    n_cmp++;
    if (snd.sample_ready !== 1'b1) begin
      n_bad++; $display("FAIL replay_ready got %b want 1", snd.sample_ready);
    end
    @(posedge sys_clk); #1;
    snd.sample_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_tick(FRAME_CYC + 50, found, cyc);
      seq = {seq[2:0], (found && underrun === 1'b1)};
    end
    n_cmp++;
    if (seq !== 4'b0111) begin
      n_bad++; $display("FAIL replay_underrun_seq got %b want 0111", seq);
    end
  endtask

  task automatic test_latch_write();
    bit found; int cyc;
    wait_tick(FRAME_CYC + 50, found, cyc);
    repeat (FRAME_CYC - 1) @(posedge sys_clk);
    #1;
    snd.sample_l = 24'($urandom); snd.sample_r = 24'($urandom); snd.sample_valid = 1'b1;
    @(posedge sys_clk); #1;
    n_cmp++;
    if ({frame_tick, underrun, snd.sample_ready} !== 3'b110) begin
      n_bad++;
      $display("FAIL latchwrite_cycle got tick/ur/ready %b want 110", {frame_tick, underrun, snd.sample_ready});
    end
    snd.sample_valid = 1'b0;
    wait_tick(FRAME_CYC + 50, found, cyc);
    n_cmp++;
    if (!found || cyc != FRAME_CYC || underrun !== 1'b0 || snd.sample_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL latchwrite_next got cycles=%0d ur=%b ready=%b want %0d/0/1", cyc, underrun, snd.sample_ready, FRAME_CYC);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit found; int cyc;
    found = 1'b0;
    for (int i = 0; i < FRAME_CYC + 50; i++) begin
      @(posedge sys_clk); #1;
      if (lrclk === 1'b1) begin found = 1'b1; break; end
    end
    repeat (37) @(posedge sys_clk);
    #2;
    n_cmp++;
    if (!found || lrclk !== 1'b1) begin
      n_bad++; $display("FAIL midreset_in_right_slot got lrclk=%b want 1", lrclk);
    end
    data_reset = 1'b1;
    #1;
    n_cmp++;
    if ({bclk, lrclk, sdata, frame_tick, underrun, snd.sample_ready} !== 6'b000001) begin
      n_bad++;
      $display("FAIL midreset_outputs got %b want 000001",
               {bclk, lrclk, sdata, frame_tick, underrun, snd.sample_ready});
    end
    repeat (3) @(posedge sys_clk);
    #1 data_reset = 1'b0;
    wait_tick(40, found, cyc);
    n_cmp++;
    if (!found || cyc != 2 * HALF || underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_restart got cycles=%0d ur=%b want %0d/1", cyc, underrun, 2 * HALF);
    end
    wait_tick(FRAME_CYC + 50, found, cyc);
    n_cmp++;
    if (!found || cyc != FRAME_CYC) begin
      n_bad++; $display("FAIL midreset_period got %0d want %0d", cyc, FRAME_CYC);
    end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_back_to_back();
    test_replay();
    test_latch_write();
    test_reset_mid_frame();
    @(posedge sys_clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
